// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port word memory between the fetch
// client (0) and the load client (1). Requests are granted round-robin, the
// strobe is held until the memory answers, and a watchdog turns a stalled
// access into an error response.
module mem_port_arbiter #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              c0_req_valid,
   input  logic [ADDR_W-1:0] c0_req_addr,
   output logic              c0_req_ready,
   output logic              c0_resp_valid,
   output logic [DATA_W-1:0] c0_resp_data,
   output logic              c0_resp_err,
   input  logic              c1_req_valid,
   input  logic [ADDR_W-1:0] c1_req_addr,
   output logic              c1_req_ready,
   output logic              c1_resp_valid,
   output logic [DATA_W-1:0] c1_resp_data,
   output logic              c1_resp_err,
   output logic [ADDR_W-1:0] mem_req_addr,
   output logic              mem_req_stb,
   input  logic [DATA_W-1:0] mem_req_data,
   input  logic              mem_req_valid
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   // Watchdog counter increment that sticks at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              owner_q, owner_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] c0_data_q, c0_data_d;
   logic [DATA_W-1:0] c1_data_q, c1_data_d;

   logic gnt_valid;
   logic gnt_id;

   // Round-robin pick: a lone requester wins; on a tie the client not served last wins.
   always_comb begin
      gnt_valid = c0_req_valid | c1_req_valid;
      gnt_id    = 1'b0;
      if (c0_req_valid && c1_req_valid) gnt_id = ~last_grant_q;
      else if (c1_req_valid)            gnt_id = 1'b1;
   end

   // Next-state logic and all outputs, decoded from the current state.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      owner_d      = owner_q;
      err_d        = err_q;
      c0_data_d    = c0_data_q;
      c1_data_d    = c1_data_q;
      c0_req_ready = 1'b0;
      c1_req_ready = 1'b0;
      mem_req_stb  = 1'b0;
      mem_req_addr = '0;
      case (state_q)
         S_IDLE: begin
            // Ready is masked while reset is held so nothing looks accepted.
            c0_req_ready = i_reset & gnt_valid & ~gnt_id;
            c1_req_ready = i_reset & gnt_valid & gnt_id;
            if (gnt_valid) begin
               addr_d       = gnt_id ? c1_req_addr : c0_req_addr;
               owner_d      = gnt_id;
               last_grant_d = gnt_id;
               cnt_d        = 8'd0;
               state_d      = S_WAIT;
            end
         end
         S_WAIT: begin
            mem_req_stb  = 1'b1;
            mem_req_addr = addr_q;
            // Memory data beats the watchdog when both happen together.
            if (mem_req_valid) begin
               if (owner_q) c1_data_d = mem_req_data;
               else         c0_data_d = mem_req_data;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == TO_LAST) begin
               if (owner_q) c1_data_d = '0;
               else         c0_data_d = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign c0_resp_valid = (state_q == S_RESP) & ~owner_q;
   assign c1_resp_valid = (state_q == S_RESP) & owner_q;
   assign c0_resp_err   = c0_resp_valid & err_q;
   assign c1_resp_err   = c1_resp_valid & err_q;
   assign c0_resp_data  = c0_data_q;
   assign c1_resp_data  = c1_data_q;

   // State and datapath registers; reset abandons any access in flight.
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= 1'b1;
         cnt_q        <= 8'd0;
         addr_q       <= '0;
         owner_q      <= 1'b0;
         err_q        <= 1'b0;
         c0_data_q    <= '0;
         c1_data_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         owner_q      <= owner_d;
         err_q        <= err_d;
         c0_data_q    <= c0_data_d;
         c1_data_q    <= c1_data_d;
      end
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-client arbiter/sequencer for the core's single-port word memory (addr/stb in, data/valid out).
- Shares the port between the instruction-fetch client (client 0) and the load client (client 1) using round-robin grant.
- Latches the winning request, holds the strobe until the memory reports valid, and returns registered data to the requester.
- Includes a watchdog that terminates a stalled access with an error response.

Parameters:
- ADDR_W, 32, width of client and memory addresses.
- DATA_W, 32, width of read data.
- TIMEOUT_CYCLES, 15, maximum number of WAIT cycles before the access is aborted. Legal range 1..255.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-low reset; 0 = reset.
- c0_req_valid  in  1  client 0 (fetch) request.
- c0_req_addr  in  ADDR_W  client 0 byte address.
- c0_req_ready  out  1  client 0 request accepted this cycle.
- c0_resp_valid  out  1  one-cycle response pulse to client 0.
- c0_resp_data  out  DATA_W  client 0 read data.
- c0_resp_err  out  1  client 0 response is a timeout.
- c1_req_valid, c1_req_addr, c1_req_ready, c1_resp_valid, c1_resp_data, c1_resp_err: same as client 0, for client 1 (load).
- mem_req_addr  out  ADDR_W  address to memory.
- mem_req_stb  out  1  memory strobe.
- mem_req_data  in  DATA_W  memory read data.
- mem_req_valid  in  1  memory data valid; may be asserted in the same cycle as the strobe.

Behaviour:
- States: IDLE, WAIT, RESP. Encoding is free.
- Reset (i_reset=0 at a clock edge):
  - state=IDLE, last_grant=1 (so client 0 wins the first tie), timeout counter=0.
  - All outputs 0: ready, resp_valid, resp_err, mem_req_stb, mem_req_addr, resp_data.
  - Reset asserted mid-access drops the access; no response is ever issued for it.
- IDLE:
  - cX_req_ready is combinational and is high only for the granted client.
  - Grant rule: if only one client is valid, grant it. If both are valid, grant the client that is not last_grant.
  - On the handshake (valid & ready at the edge): latch the address and the client id, set last_grant to that id, clear the counter, go to WAIT.
  - A client must hold valid and addr stable until it sees ready.
- WAIT:
  - mem_req_stb=1 and mem_req_addr=latched address, both stable for every WAIT cycle.
  - Both ready outputs are 0.
  - If mem_req_valid=1: capture mem_req_data, err=0, go to RESP.
  - Else if counter==TIMEOUT_CYCLES-1: data=0, err=1, go to RESP.
  - Otherwise increment the counter (8-bit, saturates; never wraps).
  - If mem_req_valid and the timeout coincide, valid wins (err=0).
- RESP:
  - The owning client's resp_valid=1 for exactly one cycle, with registered resp_data and resp_err.
  - The other client's resp outputs stay 0. mem_req_stb=0. Both ready outputs are 0.
  - Next state is always IDLE.
- Latency:
  - Handshake at edge N.
  - Strobe is driven in cycle N+1.
  - With a same-cycle-valid memory, resp_valid is high in cycle N+2.
  - A new handshake is possible at edge N+3 at the earliest (one access per 3 cycles).
- resp_data of the non-owning client holds its previous value; only the resp_valid qualifier matters.
- Memory address is passed through unmodified (byte address); word-select slicing is the memory's job.
- mem_req_valid outside WAIT is ignored.

Test Plan:
- Single client 0 read of addr 0x0000_0010, memory returns 0xDEAD_BEEF with same-cycle valid:
  - c0_req_ready at cycle 0, stb with addr 0x10 at cycle 1.
  - c0_resp_valid=1, data 0xDEAD_BEEF, err=0 at cycle 2.
  - c1 outputs stay 0 throughout.
- Both clients request continuously after reset (c0 addr 0x4, c1 addr 0x8):
  - Grants alternate c0, c1, c0, c1.
  - Each response goes to the correct client with the correct data, one access every 3 cycles.
- Memory delays valid by 3 cycles:
  - stb and addr held stable for 4 WAIT cycles, then a single resp pulse with the correct data and err=0.
- Memory never asserts valid, TIMEOUT_CYCLES=15:
  - stb is high for exactly 15 cycles, then resp_valid=1, err=1, data=0.
  - The arbiter returns to IDLE and serves the next request normally.
- i_reset driven low during WAIT of a client 1 access:
  - All outputs go to 0 on the next edge and no c1 response appears.
  - After release, simultaneous requests grant client 0 first.
- mem_req_valid=1 on the cycle the counter reaches TIMEOUT_CYCLES-1:
  - Response has err=0 and carries the memory data.
